mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/arb_tag_pipe.sv | 35 +++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, read-owner tags
// and the fixed access size used for instruction fetches.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_tag_e;

    localparam logic [2:0] FUNC3_WORD = 3'b010;

endpackage

// File: rtl/arb_tag_pipe.sv
// Owner-tag delay line: remembers which requester issued each read so the response,
// DEPTH cycles later, is steered to the right port. empty = nothing in flight.
module arb_tag_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_b,
    input  owner_tag_e tag_in,
    output owner_tag_e tag_out,
    output logic       empty
);

    owner_tag_e stage [DEPTH];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= NONE;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage[i] != NONE) empty = 1'b0;
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, with a
// halt/drain sequence. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
//
// state  | meaning
// RUN    | normal arbitration, data has priority over fetch
// DRAIN  | halt seen; fetch blocked, data still served, waiting for reads to return
// HALTED | no grants until reset
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MEM_LAT        = 1,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_func3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              halted
);

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("mem_arbiter: MEM_LAT must be at least 1");
    end
    if (MAX_DATA_BURST < 1) begin : g_bad_burst
        $error("mem_arbiter: MAX_DATA_BURST must be at least 1");
    end

    arb_state_e        state, state_nxt;
    owner_tag_e        tag_in, tag_out;
    logic              tag_empty;
    logic              fetch_ok, data_ok, force_fetch;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (halt) state_nxt = DRAIN;
            DRAIN:   if (tag_empty) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    // Grants are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        fetch_ok = (state == RUN) && !halt;
        data_ok  = (state != HALTED);
        d_gnt    = 1'b0;
        if_gnt   = 1'b0;
        if (reset) begin
            d_gnt  = data_ok && d_req && !(force_fetch && if_req && fetch_ok);
            if_gnt = fetch_ok && if_req && !d_gnt;
        end
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(MAX_DATA_BURST + 1);
    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && (starve_cnt != CNT_W'(MAX_DATA_BURST))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign force_fetch = (starve_cnt == CNT_W'(MAX_DATA_BURST));
`else
    assign force_fetch = 1'b0;
`endif

    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_func3 = '0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_func3 = d_func3;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
            mem_func3 = FUNC3_WORD;
        end
    end

    // Stores are fire-and-forget, so only reads enter the tag pipe.
    always_comb begin
        tag_in = NONE;
        if (if_gnt)             tag_in = FETCH;
        else if (d_gnt && !d_we) tag_in = DATA;
    end

    arb_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_b   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .empty   (tag_empty)
    );

    assign if_rvalid = (tag_out == FETCH);
    assign d_rvalid  = (tag_out == DATA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_rvalid) if_rdata_q <= mem_rdata;
            if (d_rvalid)  d_rdata_q  <= mem_rdata;
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata  = d_rvalid  ? mem_rdata : d_rdata_q;

    assign halted   = (state == HALTED);
    assign stall_if = reset & ((if_req & ~if_gnt) | halted);

endmodule
